// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-cycle core: sequencer state encoding
// and the opcode constants that the main control decoder also matches on.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection for the single-cycle core: jump beats a taken branch,
// which beats sequential fetch. Purely combinational.
module next_pc_mux #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic [PC_W-1:0] br_imm,
    input  logic [25:0]     jmp_idx,
    output logic [PC_W-1:0] next_pc
);

    // Pick the successor PC; the branch offset is in words, so scale by 4.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[PC_W-1:28], jmp_idx, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (br_imm << 2);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: holds the PC, the IDLE/RUN/HALT state machine,
// the single-step button edge detector and the retired-instruction counter.
module pc_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    input  logic [PC_W-1:0]   br_imm,
    input  logic [25:0]       jmp_idx,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic              advance,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             step_q;
    logic             step_rise;
    logic             self_loop;
    logic [PC_W-1:0]  next_pc;

    assign pc_plus4  = pc_q + {{(PC_W-3){1'b0}}, 3'd4};
    assign step_rise = step_btn & ~step_q;
    assign advance   = (state_q == RUN) && (run_mode || step_rise);
    assign self_loop = advance && (next_pc == pc_q);

    assign pc      = pc_q;
    assign halted  = (state_q == HALT);
    assign retired = retired_q;

    next_pc_mux #(
        .PC_W (PC_W)
    ) u_next_pc_mux (
        .pc_plus4 (pc_plus4),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .br_imm   (br_imm),
        .jmp_idx  (jmp_idx),
        .next_pc  (next_pc)
    );

    // Register state, PC, counter and the previous button level; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            step_q    <= step_btn;
        end
    end

    // Commit on advance: load the next PC, count the instruction, halt on a self-loop.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (self_loop) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        run_mode;
    logic        step_btn;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] br_imm;
    logic [25:0] jmp_idx;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        halted;
    logic [15:0] retired;

    int passCount = 0;
    int totalCount = 0;

    // Behavioural model of the sequencer.
    logic [31:0] mPc;
    bit          mRunning;
    bit          mHalted;
    int          mRetired;
    bit          mPrevBtn;

    pc_sequencer #(
        .PC_W     (32),
        .RESET_PC (32'h0),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .br_imm   (br_imm),
        .jmp_idx  (jmp_idx),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .advance  (advance),
        .halted   (halted),
        .retired  (retired)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] modelNextPc(input logic [31:0] curPc, input logic br,
                                                input logic jp, input logic z,
                                                input logic [31:0] imm, input logic [25:0] idx);
        logic [31:0] seqPc;
        seqPc = curPc + 32'd4;
        if (jp) return (seqPc & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
        if (br && z) return seqPc + imm * 32'd4;
        return seqPc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // Drives one cycle of inputs at the falling edge, checks the combinational
    // outputs before the rising edge and the registered outputs after it.
    task automatic applyStimulus(input string tag, input logic rst, input logic st, input logic mode,
                                 input logic btn, input logic br, input logic jp, input logic z,
                                 input logic [31:0] imm, input logic [25:0] idx);
        bit          expAdv;
        logic [31:0] nxt;
        reset    = rst;
        start    = st;
        run_mode = mode;
        step_btn = btn;
        branch   = br;
        jump     = jp;
        zero     = z;
        br_imm   = imm;
        jmp_idx  = idx;
        #1;
        expAdv = mRunning && (mode || (btn && !mPrevBtn));
        nxt    = modelNextPc(mPc, br, jp, z, imm, idx);
        checkOutput({tag, ":pc_plus4"}, pc_plus4, mPc + 32'd4);
        checkOutput({tag, ":advance"}, 32'(advance), 32'(expAdv));
        @(posedge clk);
        if (rst) begin
            mPc      = 32'h0;
            mRunning = 1'b0;
            mHalted  = 1'b0;
            mRetired = 0;
        end else if (expAdv) begin
            if (nxt == mPc) begin
                mRunning = 1'b0;
                mHalted  = 1'b1;
            end
            mPc      = nxt;
            mRetired = (mRetired + 1) % 65536;
        end else if (!mRunning && !mHalted && st) begin
            mRunning = 1'b1;
        end
        mPrevBtn = rst ? 1'b0 : btn;
        @(negedge clk);
        checkOutput({tag, ":pc"}, pc, mPc);
        checkOutput({tag, ":halted"}, 32'(halted), 32'(mHalted));
        checkOutput({tag, ":retired"}, 32'(retired), 32'(mRetired));
    endtask

    initial begin
        logic [31:0] imm;
        logic [31:0] snapRetired;
        mPc = 32'h0; mRunning = 1'b0; mHalted = 1'b0; mRetired = 0; mPrevBtn = 1'b0;
        reset = 1'b1; start = 1'b0; run_mode = 1'b0; step_btn = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; br_imm = '0; jmp_idx = '0;
        @(negedge clk);

        // Reset state.
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resetPc", pc, 32'h0);
        checkOutput("resetRetired", 32'(retired), 32'd0);

        // Free-run sequential fetch: one cycle to leave IDLE, then five commits.
        applyStimulus("startIdle", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("startPc", pc, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus("seq", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("seqPc20", pc, 32'd20);
        checkOutput("seqRetired5", 32'(retired), 32'd5);

        // Taken and untaken branch from 0x40.
        applyStimulus("jumpTo40", 0, 0, 1, 0, 0, 1, 0, 0, 26'h10);
        applyStimulus("brTaken", 0, 0, 1, 0, 1, 0, 1, 32'hFFFF_FFFD, 0);
        checkOutput("brTakenPc", pc, 32'h38);
        applyStimulus("jumpTo40b", 0, 0, 1, 0, 0, 1, 0, 0, 26'h10);
        applyStimulus("brUntaken", 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFD, 0);
        checkOutput("brUntakenPc", pc, 32'h44);

        // Reach 0x1000_0010 with a long branch, then jump beats branch.
        imm = (32'h1000_0010 - (mPc + 32'd4)) >> 2;
        applyStimulus("longBranch", 0, 0, 1, 0, 1, 0, 1, imm, 0);
        checkOutput("longBranchPc", pc, 32'h1000_0010);
        applyStimulus("jumpBeatsBr", 0, 0, 1, 0, 1, 1, 1, 32'd5, 26'h10);
        checkOutput("jumpBeatsBrPc", pc, 32'h1000_0040);

        // Single-step: held button gives one advance, a new press gives another.
        snapRetired = 32'(retired);
        for (int i = 0; i < 10; i++) applyStimulus("stepHold", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("stepRelease", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("stepPress2", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("stepHold2", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("stepTwoAdvances", 32'(retired), snapRetired + 32'd2);
        checkOutput("stepPc", pc, 32'h1000_0048);

        // Self-loop at 0x20 halts; later steps and free-run are ignored.
        applyStimulus("rstForLoop", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("startLoop", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("jumpTo20", 0, 0, 1, 0, 0, 1, 0, 0, 26'h8);
        applyStimulus("selfLoop", 0, 0, 1, 0, 0, 1, 0, 0, 26'h8);
        checkOutput("selfLoopHalted", 32'(halted), 32'd1);
        checkOutput("selfLoopPc", pc, 32'h20);
        checkOutput("selfLoopRetired", 32'(retired), 32'd2);
        applyStimulus("haltStep", 0, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("haltRun", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("haltPcHeld", pc, 32'h20);

        // Reset while halted.
        applyStimulus("rstHalted", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstHaltedPc", pc, 32'h0);
        checkOutput("rstHaltedFlag", 32'(halted), 32'd0);

        // A press while IDLE is discarded, not queued into RUN.
        applyStimulus("idlePress", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("startHeld", 0, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("runHeld", 0, 1, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("noQueuedStep", 32'(retired), 32'd0);

        // Reset mid-RUN at 0x30.
        applyStimulus("jumpTo30", 0, 1, 1, 0, 0, 1, 0, 0, 26'hC);
        checkOutput("at30", pc, 32'h30);
        applyStimulus("rstMidRun", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstMidRunPc", pc, 32'h0);
        checkOutput("rstMidRunRetired", 32'(retired), 32'd0);

        // Randomized run with mode switching, branches, jumps and occasional self-loops.
        for (int i = 0; i < 300; i++) begin
            if (mHalted || $urandom_range(0, 99) == 0) begin
                applyStimulus("rndReset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                imm = 32'($urandom_range(0, 6)) - 32'd3;
                applyStimulus("rnd", 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                              imm, 26'($urandom_range(0, 31)));
            end
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
